// File: rtl/sweep_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sweep_scheduler
// Brief   : Pan/tilt calibration sequencer. Runs a horizontal then a vertical
//           sweep, tracks the brightest ADC step, and returns each axis to it.
//           Optional macro SWEEP_TIMEOUT_EN: a sweep step with no ADC sample
//           raises sticky ERR and aborts to IDLE.
// Revision: 1.0 - initial release
// ============================================================================
module sweep_scheduler #(
    parameter int POS_W   = 8,
    parameter int ADC_W   = 12,
    parameter int DWELL   = 32,
    parameter int MAX_POS = 255
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    input  logic             H_LIMIT,
    input  logic             V_LIMIT,
    output logic             HS,
    output logic             VS,
    output logic             RET_H,
    output logic             RET_V,
    output logic             BUSY,
    output logic             DONE,
    output logic [POS_W-1:0] BEST_H,
    output logic [POS_W-1:0] BEST_V,
    output logic [ADC_W-1:0] BEST_VAL,
    output logic             ERR
);

    localparam int               CNT_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] C_STEP_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [POS_W-1:0] C_POS_LAST  = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] C_POS_ONE   = POS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_H_SWEEP = 3'd1,
        S_H_RET   = 3'd2,
        S_V_SWEEP = 3'd3,
        S_V_RET   = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [POS_W-1:0] r_pos_h;
    logic [POS_W-1:0] r_pos_v;
    logic [POS_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_step_cnt;
    logic [ADC_W-1:0] r_adc_last;
    logic [POS_W-1:0] r_best_h;
    logic [POS_W-1:0] r_best_v;
    logic [ADC_W-1:0] r_best_val;
    logic             r_hs;
    logic             r_vs;
    logic             r_ret_h;
    logic             r_ret_v;
    logic             r_busy;
    logic             r_done;

    logic             w_step_end;
    logic             w_is_v;
    logic             w_sweep;
    logic             w_ret_state;
    logic             w_better;
    logic             w_at_limit;
    logic             w_timeout;
    logic             w_go;
    logic [POS_W-1:0] w_pos;
    logic [POS_W-1:0] w_best_pos;
    logic [POS_W-1:0] w_new_best;
    logic [POS_W-1:0] w_ret_new;

    assign w_step_end  = (r_step_cnt == C_STEP_LAST);
    assign w_is_v      = (r_state == S_V_SWEEP);
    assign w_sweep     = (r_state == S_H_SWEEP) || w_is_v;
    assign w_ret_state = (r_state == S_H_RET) || (r_state == S_V_RET);
    assign w_pos       = w_is_v ? r_pos_v : r_pos_h;
    assign w_best_pos  = w_is_v ? r_best_v : r_best_h;
    // Strict compare: a tie keeps the earlier (already recorded) position.
    assign w_better    = (r_adc_last > r_best_val);
    assign w_new_best  = w_better ? w_pos : w_best_pos;
    assign w_ret_new   = w_pos - w_new_best;
    assign w_at_limit  = (w_is_v ? V_LIMIT : H_LIMIT) || (w_pos == C_POS_LAST);
    assign w_go        = !ABORT && !w_timeout;

`ifdef SWEEP_TIMEOUT_EN
    logic r_seen;
    logic r_err;

    assign w_timeout = w_sweep && w_step_end && !(r_seen || ADC_VALID);
    assign ERR       = r_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_seen <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || w_step_end) begin
                r_seen <= 1'b0;
            end else if (ADC_VALID) begin
                r_seen <= 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if ((r_state == S_IDLE) && START && !ABORT) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign ERR       = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_go) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (START) w_state_nxt = S_H_SWEEP;
                S_H_SWEEP: if (w_step_end && w_at_limit)
                               w_state_nxt = (w_ret_new == '0) ? S_V_SWEEP : S_H_RET;
                S_H_RET:   if (w_step_end && (r_ret_cnt == C_POS_ONE))
                               w_state_nxt = S_V_SWEEP;
                S_V_SWEEP: if (w_step_end && w_at_limit)
                               w_state_nxt = (w_ret_new == '0) ? S_FIN : S_V_RET;
                S_V_RET:   if (w_step_end && (r_ret_cnt == C_POS_ONE))
                               w_state_nxt = S_FIN;
                S_FIN:     w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Enables, BUSY and DONE are decoded from the next state so they are
    // flop outputs that rise in the first cycle of their state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
            r_ret_h    <= 1'b0;
            r_ret_v    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_step_cnt <= '0;
            r_adc_last <= '0;
            r_pos_h    <= '0;
            r_pos_v    <= '0;
            r_ret_cnt  <= '0;
            r_best_h   <= '0;
            r_best_v   <= '0;
            r_best_val <= '0;
        end else begin
            if (ADC_VALID) r_adc_last <= ADC_DATA;

            r_hs    <= (w_state_nxt == S_H_SWEEP);
            r_vs    <= (w_state_nxt == S_V_SWEEP);
            r_ret_h <= (w_state_nxt == S_H_RET);
            r_ret_v <= (w_state_nxt == S_V_RET);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_FIN);

            if ((w_state_nxt != r_state) || w_step_end) begin
                r_step_cnt <= '0;
            end else if (w_sweep || w_ret_state) begin
                r_step_cnt <= r_step_cnt + C_CNT_ONE;
            end

            if (w_go) begin
                if ((r_state == S_IDLE) && START) begin
                    r_pos_h    <= '0;
                    r_best_h   <= '0;
                    r_best_val <= '0;
                end
                if (w_sweep && w_step_end) begin
                    if (w_better) begin
                        r_best_val <= r_adc_last;
                        if (w_is_v) r_best_v <= r_pos_v;
                        else        r_best_h <= r_pos_h;
                    end
                    if (w_at_limit)  r_ret_cnt <= w_ret_new;
                    else if (w_is_v) r_pos_v   <= r_pos_v + C_POS_ONE;
                    else             r_pos_h   <= r_pos_h + C_POS_ONE;
                end
                if (w_ret_state && w_step_end) begin
                    r_ret_cnt <= r_ret_cnt - C_POS_ONE;
                end
                // Vertical entry wipes BEST_VAL after the horizontal result is latched.
                if ((w_state_nxt == S_V_SWEEP) && (r_state != S_V_SWEEP)) begin
                    r_pos_v    <= '0;
                    r_best_v   <= '0;
                    r_best_val <= '0;
                end
            end
        end
    end

    assign HS       = r_hs;
    assign VS       = r_vs;
    assign RET_H    = r_ret_h;
    assign RET_V    = r_ret_v;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign BEST_H   = r_best_h;
    assign BEST_V   = r_best_v;
    assign BEST_VAL = r_best_val;

endmodule
`default_nettype wire

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Calibration sequencer for the pan/tilt servo tracker; sits above the horizontal and vertical counter blocks and drives their sweep enables.
- On START it runs a horizontal sweep, then a vertical sweep, recording the best ADC (light) reading and its step position.
- It then steps each axis back to its best position and reports the result.

Parameters:
- POS_W, 8: width of the step position counters.
- ADC_W, 12: width of the ADC sample.
- DWELL, 32: clock cycles per step (minimum 2).
- MAX_POS, 255: last legal step index per axis (must be < 2^POS_W).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  calibration request, sampled in IDLE only.
- ABORT  in  1  synchronous abort, any state.
- ADC_DATA  in  ADC_W  light sample.
- ADC_VALID  in  1  ADC_DATA qualifier.
- H_LIMIT  in  1  horizontal servo limit reached.
- V_LIMIT  in  1  vertical servo limit reached.
- HS  out  1  horizontal sweep enable (forward).
- VS  out  1  vertical sweep enable (forward, toward the CNT_D direction).
- RET_H  out  1  horizontal return enable (reverse).
- RET_V  out  1  vertical return enable (reverse).
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- BEST_H  out  POS_W  best horizontal step index.
- BEST_V  out  POS_W  best vertical step index.
- BEST_VAL  out  ADC_W  best sample of the last sweep.
- ERR  out  1  sticky timeout flag (only with SWEEP_TIMEOUT_EN, else tied 0).

Behaviour:
- Reset: state IDLE; all outputs, pos_h, pos_v, step_cnt, adc_last and ret_cnt are 0.
- adc_last captures ADC_DATA on any cycle with ADC_VALID=1, in every state.
- States: IDLE, H_SWEEP, H_RET, V_SWEEP, V_RET, FIN.
- IDLE + START=1: next cycle enters H_SWEEP. On entry, pos_h=0, step_cnt=0, BEST_VAL=0, BEST_H=0. START while BUSY is ignored.
- H_SWEEP: HS=1. step_cnt increments every cycle. At step_cnt==DWELL-1 (step boundary):
  - Compare adc_last > BEST_VAL (strict; ties keep the earlier position). If true, BEST_VAL<=adc_last and BEST_H<=pos_h.
  - If H_LIMIT=1 or pos_h==MAX_POS: go to H_RET with ret_cnt = pos_h - new BEST_H.
  - Otherwise pos_h++ and step_cnt=0.
- H_RET: RET_H=1 for ret_cnt*DWELL cycles, decrementing ret_cnt at each step boundary.
  - ret_cnt==0 on entry: leave after 0 cycles, i.e. go straight to V_SWEEP with RET_H never asserted.
  - On entry to V_SWEEP: pos_v=0, BEST_VAL=0, BEST_V=0.
- V_SWEEP / V_RET: identical rules using VS, V_LIMIT, pos_v, BEST_V, RET_V. V_RET exits to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE. BEST_* hold until the next START.
- At most one of HS, VS, RET_H, RET_V is high in any cycle. All four are registered outputs asserted in the first cycle of their state.
- A limit asserted mid-step is only acted on at the step boundary; the current step always completes.
- ABORT=1: next cycle is IDLE with all enables low, no DONE pulse, BEST_* frozen. ABORT has priority over a simultaneous step boundary or START.
- Reset mid-sweep: immediate return to the reset values.
- Position counters never wrap, because MAX_POS bounds them.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - A per-step flag records whether any ADC_VALID arrived during the step.
  - A sweep step boundary with no valid sample sets ERR=1 and aborts to IDLE (same as ABORT).
  - ERR clears on the next accepted START.
- Undefined: no flag logic; ERR constant 0; stale adc_last is compared.

Test Plan:
- DWELL=4, MAX_POS=7, ADC ramp 10,20..80 each step with no limits:
  - HS high 32 cycles, BEST_H=7, RET_H never high.
  - Vertical sweep mirrors this; DONE pulses once, BEST_VAL=80.
- Horizontal samples 5,90,40,90,10,... with H_LIMIT raised during step 4:
  - Sweep ends at pos_h=4, BEST_H=1 (tie keeps the earlier position).
  - RET_H high for exactly 12 cycles.
- ABORT pulsed in cycle 6 of H_SWEEP:
  - Next cycle IDLE; HS=0, BUSY=0, DONE never pulses.
  - A subsequent START restarts from pos_h=0.
- RST_N low mid V_RET (async, between edges):
  - All outputs 0 immediately.
  - START before release has no effect; after release, START starts a fresh H_SWEEP.
- START held high through a full calibration:
  - Exactly one calibration runs; a new one starts the cycle after DONE's IDLE.
- With SWEEP_TIMEOUT_EN, ADC_VALID withheld during step 2 of V_SWEEP:
  - ERR=1 at that step boundary, return to IDLE.
  - ERR clears on the next START.
